// File: rtl/key_debounce_1k_if.sv
// Key debouncer bus: raw keys and the 1 kHz reference in,
// debounced level and event pulses out.
`timescale 1ns/1ps
interface key_debounce_1k_if #(
    parameter int N_KEYS = 4
);
    logic              clk_1k;
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;

    modport master (
        output clk_1k,
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  clk_1k,
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce_1k.sv
// Multi-key debouncer: 1 ms tick from clk_1k, per-key press,
// release and long-press classification in the clk domain.
`timescale 1ns/1ps
module key_debounce_1k #(
    parameter int N_KEYS     = 4,
    parameter int DEB_MS     = 20,
    parameter int LONG_MS    = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    key_debounce_1k_if.slave bus
);
    localparam int CW = $clog2(LONG_MS + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_MS - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [N_KEYS-1:0] IDLE_LVL = {N_KEYS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        REL_DEB
    } state_t;

    logic              c1k_s1;
    logic              c1k_s2;
    logic              c1k_d;
    logic              tick;
    logic [N_KEYS-1:0] key_s1;
    logic [N_KEYS-1:0] key_s2;
    logic [N_KEYS-1:0] act;

    state_t            state [N_KEYS];
    logic [CW-1:0]     cnt   [N_KEYS];
    logic [N_KEYS-1:0] long_done;
    logic [N_KEYS-1:0] level_q;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] rel_q;
    logic [N_KEYS-1:0] long_q;

    // clk_1k is only data here: sync, then a registered rising-edge tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c1k_s1 <= 1'b0;
            c1k_s2 <= 1'b0;
            c1k_d  <= 1'b0;
            tick   <= 1'b0;
        end else begin
            c1k_s1 <= bus.clk_1k;
            c1k_s2 <= c1k_s1;
            c1k_d  <= c1k_s2;
            tick   <= c1k_s2 & ~c1k_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_s1 <= IDLE_LVL;
            key_s2 <= IDLE_LVL;
        end else begin
            key_s1 <= bus.key_in;
            key_s2 <= key_s1;
        end
    end

    assign act = key_s2 ^ IDLE_LVL;

    // Abort on act change always beats a same-cycle tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_KEYS; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            long_done <= '0;
            level_q   <= '0;
            press_q   <= '0;
            rel_q     <= '0;
            long_q    <= '0;
        end else begin
            press_q <= '0;
            rel_q   <= '0;
            long_q  <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                unique case (state[i])
                    IDLE: begin
                        if (act[i]) begin
                            state[i] <= PRESS_DEB;
                            cnt[i]   <= '0;
                        end
                    end
                    PRESS_DEB: begin
                        if (!act[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (tick) begin
                            if (cnt[i] == DEB_LAST) begin
                                state[i]   <= HELD;
                                cnt[i]     <= '0;
                                level_q[i] <= 1'b1;
                                press_q[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + CNT_ONE;
                            end
                        end
                    end
                    HELD: begin
                        if (!act[i]) begin
                            state[i] <= REL_DEB;
                            cnt[i]   <= '0;
                        end else if (tick && !long_done[i]) begin
                            if (cnt[i] == LONG_LAST) begin
                                long_q[i]    <= 1'b1;
                                long_done[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + CNT_ONE;
                            end
                        end
                    end
                    REL_DEB: begin
                        // long_done survives a bounce back into HELD
                        if (act[i]) begin
                            state[i] <= HELD;
                            cnt[i]   <= '0;
                        end else if (tick) begin
                            if (cnt[i] == DEB_LAST) begin
                                state[i]     <= IDLE;
                                cnt[i]       <= '0;
                                level_q[i]   <= 1'b0;
                                rel_q[i]     <= 1'b1;
                                long_done[i] <= 1'b0;
                            end else begin
                                cnt[i] <= cnt[i] + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.key_level   = level_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = rel_q;
    assign bus.key_long    = long_q;
endmodule

// File: tb/tb_key_debounce_1k.sv
// Scoreboard bench for key_debounce_1k: expected events are queued
// with the 1 ms tick they must land on and matched as pulses appear.
`timescale 1ns/1ps
module tb_key_debounce_1k;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0] p;
        logic [N-1:0] r;
        logic [N-1:0] l;
        int           t;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic run_1k = 1'b1;
    logic c1k = 1'b0;
    int   div = 0;
    int   ticks = 0;

    int n_total = 0;
    int n_pass = 0;
    int inv_err = 0;

    ev_t          exp_q[$];
    ev_t          me;
    logic [N-1:0] prev_lvl = '0;
    logic         prev_rst = 1'b0;

    key_debounce_1k_if #(.N_KEYS(N)) bus ();

    key_debounce_1k #(
        .N_KEYS    (N),
        .DEB_MS    (4),
        .LONG_MS   (10),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // 20-clk period reference; ticks counts its rising edges
    always @(negedge clk) begin
        if (run_1k) begin
            if (div == 9) begin
                div <= 0;
                c1k <= ~c1k;
                if (!c1k) ticks <= ticks + 1;
            end else begin
                div <= div + 1;
            end
        end
    end

    assign bus.clk_1k = c1k;

    always @(negedge clk) begin
        if ((bus.key_press | bus.key_release | bus.key_long) != '0) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL event: got p=%b r=%b l=%b tick=%0d, required no event",
                         bus.key_press, bus.key_release, bus.key_long, ticks);
            end else begin
                me = exp_q.pop_front();
                if ({bus.key_press, bus.key_release, bus.key_long, ticks}
                    !== {me.p, me.r, me.l, me.t})
                    $display("FAIL event: got p=%b r=%b l=%b tick=%0d, required p=%b r=%b l=%b tick=%0d",
                             bus.key_press, bus.key_release, bus.key_long, ticks,
                             me.p, me.r, me.l, me.t);
                else
                    n_pass++;
            end
        end
        if (rst && prev_rst) begin
            for (int i = 0; i < N; i++) begin
                if (int'(bus.key_press[i]) + int'(bus.key_release[i])
                    + int'(bus.key_long[i]) > 1)
                    inv_err++;
                if (bus.key_level[i] != prev_lvl[i]
                    && !(bus.key_press[i] || bus.key_release[i]))
                    inv_err++;
            end
        end
        prev_lvl = bus.key_level;
        prev_rst = rst;
    end

    task automatic push(input logic [N-1:0] p, input logic [N-1:0] r,
                        input logic [N-1:0] l, input int t);
        ev_t e;
        e.p = p;
        e.r = r;
        e.l = l;
        e.t = t;
        exp_q.push_back(e);
    endtask

    // Returns 3 clk after a clk_1k rising edge, well clear of the next one
    task automatic align();
        int t0;
        t0 = ticks;
        for (int i = 0; i < 50 && ticks == t0; i++) @(negedge clk);
        if (ticks == t0) begin
            n_total++;
            $display("FAIL align: tick count stuck at %0d, required %0d", ticks, t0 + 1);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.key_in = '1;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (bus.key_level !== '0) $display("FAIL rst_level: got %b, required 0000", bus.key_level);
        else n_pass++;
        n_total++;
        if (bus.key_press !== '0) $display("FAIL rst_press: got %b, required 0000", bus.key_press);
        else n_pass++;
        n_total++;
        if (bus.key_release !== '0) $display("FAIL rst_release: got %b, required 0000", bus.key_release);
        else n_pass++;
        n_total++;
        if (bus.key_long !== '0) $display("FAIL rst_long: got %b, required 0000", bus.key_long);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int t;
        align();
        t = ticks;
        bus.key_in[0] = 1'b0;
        push(4'b0001, 4'b0000, 4'b0000, t + 4);
        push(4'b0000, 4'b0000, 4'b0001, t + 14);
        repeat (30) align();
        n_total++;
        if (bus.key_level[0] !== 1'b1) $display("FAIL clean_level_hi: got %b, required 1", bus.key_level[0]);
        else n_pass++;
        t = ticks;
        bus.key_in[0] = 1'b1;
        push(4'b0000, 4'b0001, 4'b0000, t + 4);
        repeat (6) align();
        n_total++;
        if (bus.key_level[0] !== 1'b0) $display("FAIL clean_level_lo: got %b, required 0", bus.key_level[0]);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL clean_pending: got %0d events left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_bounce();
        int t;
        align();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            bus.key_in[1] = ~bus.key_in[1];
            if (k < 8) repeat (7) @(negedge clk);
        end
        t = ticks;
        push(4'b0010, 4'b0000, 4'b0000, t + 4);
        repeat (6) align();
        n_total++;
        if (bus.key_level[1] !== 1'b1) $display("FAIL bounce_level: got %b, required 1", bus.key_level[1]);
        else n_pass++;
        t = ticks;
        bus.key_in[1] = 1'b1;
        push(4'b0000, 4'b0010, 4'b0000, t + 4);
        repeat (6) align();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL bounce_pending: got %0d events left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_glitch();
        align();
        bus.key_in[2] = 1'b0;
        repeat (2) align();
        bus.key_in[2] = 1'b1;
        repeat (6) align();
        n_total++;
        if (bus.key_level[2] !== 1'b0) $display("FAIL glitch_level: got %b, required 0", bus.key_level[2]);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL glitch_pending: got %0d events left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_release_glitch();
        int   t;
        logic drop;
        drop = 1'b0;
        align();
        t = ticks;
        bus.key_in[0] = 1'b0;
        push(4'b0001, 4'b0000, 4'b0000, t + 4);
        push(4'b0000, 4'b0000, 4'b0001, t + 14);
        repeat (16) align();
        bus.key_in[0] = 1'b1;
        repeat (2) begin
            align();
            if (bus.key_level[0] !== 1'b1) drop = 1'b1;
        end
        bus.key_in[0] = 1'b0;
        repeat (14) begin
            align();
            if (bus.key_level[0] !== 1'b1) drop = 1'b1;
        end
        n_total++;
        if (drop !== 1'b0) $display("FAIL relglitch_level: got level drop=%b, required 0", drop);
        else n_pass++;
        t = ticks;
        bus.key_in[0] = 1'b1;
        push(4'b0000, 4'b0001, 4'b0000, t + 4);
        repeat (6) align();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL relglitch_pending: got %0d events left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t;
        align();
        t = ticks;
        bus.key_in = 4'b0110;
        push(4'b1001, 4'b0000, 4'b0000, t + 4);
        push(4'b0000, 4'b0000, 4'b1001, t + 14);
        repeat (16) align();
        n_total++;
        if (bus.key_level !== 4'b1001) $display("FAIL concur_level: got %b, required 1001", bus.key_level);
        else n_pass++;
        t = ticks;
        bus.key_in = 4'b1111;
        push(4'b0000, 4'b1001, 4'b0000, t + 4);
        repeat (6) align();
        n_total++;
        if (bus.key_level !== 4'b0000) $display("FAIL concur_level_lo: got %b, required 0000", bus.key_level);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL concur_pending: got %0d events left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_stall();
        int t;
        align();
        t = ticks;
        bus.key_in[1] = 1'b0;
        push(4'b0010, 4'b0000, 4'b0000, t + 4);
        repeat (6) align();
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus.key_level, bus.key_press, bus.key_release, bus.key_long} !== '0)
            $display("FAIL midrst_out: got lvl=%b p=%b r=%b l=%b, required all 0",
                     bus.key_level, bus.key_press, bus.key_release, bus.key_long);
        else n_pass++;
        @(negedge clk);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        t = ticks;
        push(4'b0010, 4'b0000, 4'b0000, t + 4);
        repeat (6) align();
        n_total++;
        if (bus.key_level[1] !== 1'b1) $display("FAIL midrst_level: got %b, required 1", bus.key_level[1]);
        else n_pass++;
        t = ticks;
        bus.key_in[1] = 1'b1;
        push(4'b0000, 4'b0010, 4'b0000, t + 4);
        repeat (6) align();
        align();
        repeat (8) @(negedge clk);
        run_1k = 1'b0;
        bus.key_in[2] = 1'b0;
        repeat (200) @(negedge clk);
        n_total++;
        if (bus.key_level[2] !== 1'b0) $display("FAIL stall_level: got %b, required 0", bus.key_level[2]);
        else n_pass++;
        bus.key_in[2] = 1'b1;
        repeat (10) @(negedge clk);
        run_1k = 1'b1;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL stall_pending: got %0d events left, required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.key_in = '1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release_glitch();
        test_back_to_back();
        test_reset_stall();
        n_total++;
        if (inv_err != 0) $display("FAIL invariants: got %0d violations, required 0", inv_err);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/key_debounce_1k.md
Name: key_debounce_1k

Overview:
Multi-key debouncer and press classifier that consumes the 1 kHz square wave from the clock divider. It runs entirely in the system clock domain (100 MHz). It derives a one-cycle 1 ms tick from clk_1k and debounces N_KEYS raw push-buttons. It emits a debounced level plus single-cycle press, release and long-press pulses to downstream control logic.

Parameters:
N_KEYS, 4, number of independent keys
DEB_MS, 20, debounce window in 1 ms ticks (>=2)
LONG_MS, 1000, held time in ticks before key_long fires (>DEB_MS)
ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-low reset
clk_1k  in  1  1 kHz square wave from the divider (async to use, treated as data)
key_in  in  N_KEYS  raw mechanical key inputs, asynchronous
key_level  out  N_KEYS  debounced state, 1 = pressed
key_press  out  N_KEYS  1-clk pulse on debounced press
key_release  out  N_KEYS  1-clk pulse on debounced release
key_long  out  N_KEYS  1-clk pulse once per hold when held LONG_MS ticks

Behaviour:
- Reset is async active-low; clk is the clock. While rst=0:
  - All outputs are 0 and all FSMs are IDLE.
  - Counters are 0 and long_done flags are cleared.
  - clk_1k sync/edge registers are 0.
  - Key sync registers hold the inactive level (1 if ACTIVE_LOW, else 0).
- Tick generation:
  - clk_1k passes through a 2-FF synchronizer, then an edge register.
  - tick = 1 for exactly one clk cycle on each synchronized rising edge of clk_1k.
  - If clk_1k is stuck at either level, no ticks occur and no FSM advances on time; abort paths still work.
- Key conditioning:
  - Each key_in bit passes through a 2-FF synchronizer.
  - act[i] = sync[i] XOR ACTIVE_LOW, so act=1 means pressed.
- Per-key FSM: states IDLE, PRESS_DEB, HELD, REL_DEB. Each key has a counter cnt of width clog2(LONG_MS+1), and a long_done flag.
  - IDLE: if act=1, go to PRESS_DEB with cnt=0.
  - PRESS_DEB:
    - act=0 on any cycle: go to IDLE, cnt=0, no pulse.
    - Otherwise each tick increments cnt.
    - On a tick with cnt==DEB_MS-1: go to HELD, cnt=0, key_level=1, key_press pulse.
  - HELD:
    - act=0: go to REL_DEB, cnt=0.
    - Otherwise each tick increments cnt while long_done=0.
    - On a tick with cnt==LONG_MS-1 and long_done=0: key_long pulse, long_done=1, cnt holds (saturates).
  - REL_DEB:
    - act=1 on any cycle: go to HELD with cnt=0; long_done is kept, so no second key_long per hold.
    - Otherwise each tick increments cnt.
    - On a tick with cnt==DEB_MS-1: go to IDLE, key_level=0, key_release pulse, long_done=0.
- Timing:
  - Effective debounce is between DEB_MS-1 and DEB_MS ms, because the first tick phase is arbitrary.
  - All outputs are registered. Each pulse is high exactly the clk cycle after the qualifying tick cycle.
  - Latency from a clk_1k rising edge to a pulse is 4 clk cycles.
- Keys are fully independent. Simultaneous events on different keys each produce their own pulses in the same cycle.
- Simultaneous tick and act change in the same cycle: the abort (act change) wins, and the counter does not advance that cycle.
- Within one key, key_press, key_release and key_long are never high in the same cycle.
- key_level changes only in the cycle its press/release pulse is high.
- Reset mid-operation: outputs clear immediately (asynchronously). After rst deasserts with a key still pressed, a fresh full debounce is required before key_press.

Test Plan:
(Bench overrides DEB_MS=4, LONG_MS=10, N_KEYS=4, ACTIVE_LOW=1; drives clk_1k with a 20-clk period.)
1. Clean press: key_in[0] low for 30 ticks, then high -> exactly one key_press[0] after the 4th tick; key_level[0]=1. One key_long[0] at the 10th tick in HELD. After release, key_release[0] follows the 4th tick and key_level[0]=0.
2. Press bounce: key_in[1] toggles every 7 clk for 3 ms, then stays low -> no pulses during the bounce. Exactly one key_press[1], 4 ticks after the last edge.
3. Short glitch: key_in[2] low for 2 ticks only -> key_level, key_press and key_release on bit 2 all stay 0.
4. Release glitch: key 0 held past key_long, then released for 2 ticks and pressed again -> no key_release and no second key_long. key_level[0] stays 1 throughout.
5. Concurrency: keys 0 and 3 pressed in the same cycle -> key_press=4'b1001 in a single cycle. Other bits are unaffected.
6. Reset and stall: assert rst while key 1 is HELD -> all outputs 0 at once; after deassert, key_press[1] comes only after 4 new ticks. With clk_1k held at 0, no press is ever reported.
